// File: rtl/e1_demux_controller.sv
`default_nettype none
// ============================================================================
// Module   : e1_demux_controller
// Purpose  : E1 frame alignment and timeslot sequencer. Finds the FAS word in
//            the serial stream and confirms it with a FAS/NFAS/FAS sequence.
//            Once aligned, it emits each timeslot byte tagged with its
//            timeslot index and frame parity. Repeated FAS errors drop the
//            alignment and return the block to search.
// Revision : 1.0 - initial release
// ============================================================================
module e1_demux_controller #(
  parameter logic [6:0]  FAS_PATTERN = 7'b0011011,
  parameter int unsigned LOSS_THRESH = 3,
  parameter int unsigned NUM_TS      = 32
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       din,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic [4:0] ts_num,
  output logic       odd_frame,
  output logic       frame_sync,
  output logic       fas_err
);

  localparam int unsigned TS_W  = $clog2(NUM_TS);
  localparam int unsigned ERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [TS_W-1:0]  c_ts_last = TS_W'(NUM_TS - 1);
  localparam logic [TS_W-1:0]  c_ts_one  = TS_W'(1);
  localparam logic [ERR_W-1:0] c_err_max = ERR_W'(LOSS_THRESH);
  localparam logic [ERR_W-1:0] c_err_one = ERR_W'(1);

  typedef enum logic [1:0] {
    ST_SEARCH   = 2'd0,
    ST_CHK_NFAS = 2'd1,
    ST_CHK_FAS  = 2'd2,
    ST_SYNC     = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  // Only the seven most recent bits are needed to form the incoming byte.
  logic [6:0]       sreg_q,       sreg_d;
  logic [2:0]       bit_cnt_q,    bit_cnt_d;
  logic [TS_W-1:0]  ts_cnt_q,     ts_cnt_d;
  logic             parity_q,     parity_d;
  logic [ERR_W-1:0] err_cnt_q,    err_cnt_d;
  logic [7:0]       dout_q,       dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [4:0]       ts_num_q,     ts_num_d;
  logic             odd_frame_q,  odd_frame_d;
  logic             frame_sync_q, frame_sync_d;
  logic             fas_err_q,    fas_err_d;

  logic [7:0]       in_byte;
  logic             fas_match;
  logic             byte_end;
  logic             ts0_end;
  logic [ERR_W-1:0] err_inc;

  // Byte completed by the bit arriving on this edge, and the events it marks.
  assign in_byte   = {sreg_q, din};
  assign fas_match = (in_byte[6:0] == FAS_PATTERN);
  assign byte_end  = (bit_cnt_q == 3'd7);
  assign ts0_end   = byte_end && (ts_cnt_q == '0);
  assign err_inc   = (err_cnt_q == c_err_max) ? err_cnt_q : err_cnt_q + c_err_one;

  // State register and all datapath registers; clear discards alignment.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q      <= ST_SEARCH;
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      ts_cnt_q     <= '0;
      parity_q     <= 1'b0;
      err_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      ts_num_q     <= '0;
      odd_frame_q  <= 1'b0;
      frame_sync_q <= 1'b0;
      fas_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      ts_cnt_q     <= ts_cnt_d;
      parity_q     <= parity_d;
      err_cnt_q    <= err_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      ts_num_q     <= ts_num_d;
      odd_frame_q  <= odd_frame_d;
      frame_sync_q <= frame_sync_d;
      fas_err_q    <= fas_err_d;
    end
  end

  // Next-state logic: bit/timeslot counting, alignment FSM, byte output.
  always_comb begin
    state_d      = state_q;
    sreg_d       = in_byte[6:0];
    bit_cnt_d    = bit_cnt_q;
    ts_cnt_d     = ts_cnt_q;
    parity_d     = parity_q;
    err_cnt_d    = err_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    ts_num_d     = ts_num_q;
    odd_frame_d  = odd_frame_q;
    fas_err_d    = 1'b0;

    // The frame position advances only while an alignment is being tracked;
    // in search the counters hold until the next candidate FAS resets them.
    if (state_q != ST_SEARCH) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (byte_end) begin
        if (ts_cnt_q == c_ts_last) begin
          ts_cnt_d = '0;
          parity_d = ~parity_q;
        end else begin
          ts_cnt_d = ts_cnt_q + c_ts_one;
        end
      end
    end

    case (state_q)
      ST_SEARCH: begin
        // The candidate FAS byte is TS0 of an even frame; the next bit
        // is therefore bit 0 of TS1.
        if (fas_match) begin
          bit_cnt_d = '0;
          ts_cnt_d  = c_ts_one;
          parity_d  = 1'b0;
          state_d   = ST_CHK_NFAS;
        end
      end

      ST_CHK_NFAS: begin
        // One frame later TS0 must carry an NFAS word (bit 2 set).
        if (ts0_end) begin
          state_d = in_byte[6] ? ST_CHK_FAS : ST_SEARCH;
        end
      end

      ST_CHK_FAS: begin
        // Two frames later the FAS word must reappear.
        if (ts0_end) begin
          if (fas_match) begin
            state_d   = ST_SYNC;
            err_cnt_d = '0;
          end else begin
            state_d   = ST_SEARCH;
          end
        end
      end

      ST_SYNC: begin
        if (byte_end) begin
          dout_d       = in_byte;
          ts_num_d     = 5'(ts_cnt_q);
          odd_frame_d  = parity_q;
          dout_valid_d = 1'b1;
          // Only even-frame TS0 is supervised; NFAS content is not checked.
          if ((ts_cnt_q == '0) && !parity_q) begin
            if (fas_match) begin
              err_cnt_d = '0;
            end else begin
              fas_err_d = 1'b1;
              err_cnt_d = err_inc;
              if (err_inc == c_err_max) begin
                state_d = ST_SEARCH;
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_SEARCH;
      end
    endcase

    frame_sync_d = (state_d == ST_SYNC);
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ts_num     = ts_num_q;
  assign odd_frame  = odd_frame_q;
  assign frame_sync = frame_sync_q;
  assign fas_err    = fas_err_q;

endmodule
`default_nettype wire

// File: tb/tb_e1_demux_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_e1_demux_controller
// Purpose  : Directed self-checking bench for e1_demux_controller. The stream
//            uses TS0 = 8'h1B (even) / 8'h40 (odd) and TSn = n elsewhere.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e1_demux_controller;

  logic       clock = 1'b0;
  logic       clear;
  logic       din;
  logic [7:0] dout,       t1_dout;
  logic       dout_valid, t1_dout_valid;
  logic [4:0] ts_num,     t1_ts_num;
  logic       odd_frame,  t1_odd_frame;
  logic       frame_sync, t1_frame_sync;
  logic       fas_err,    t1_fas_err;

  int errors = 0;
  int checks = 0;

  e1_demux_controller dut (
    .clock      (clock),
    .clear      (clear),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .ts_num     (ts_num),
    .odd_frame  (odd_frame),
    .frame_sync (frame_sync),
    .fas_err    (fas_err)
  );

  e1_demux_controller #(.LOSS_THRESH(1)) dut_t1 (
    .clock      (clock),
    .clear      (clear),
    .din        (din),
    .dout       (t1_dout),
    .dout_valid (t1_dout_valid),
    .ts_num     (t1_ts_num),
    .odd_frame  (t1_odd_frame),
    .frame_sync (t1_frame_sync),
    .fas_err    (t1_fas_err)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] exp_byte(input int ts, input logic odd);
    if (ts == 0) return odd ? 8'h40 : 8'h1B;
    return 8'(ts);
  endfunction

  // Drive one bit before the rising edge; return just after that edge.
  task automatic send_bit(input logic b);
    @(negedge clock);
    din = b;
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_ts_range(input logic odd, input int first, input int last);
    for (int ts = first; ts <= last; ts++) send_byte(exp_byte(ts, odd));
  endtask

  task automatic pulse_reset;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
  endtask

  // Reset, then E0/O1/E2: aligned at the end of E2 TS0; next frame is odd.
  task automatic align_stream;
    pulse_reset();
    send_ones(37);
    send_ts_range(1'b0, 0, 31);
    send_ts_range(1'b1, 0, 31);
    send_ts_range(1'b0, 0, 31);
  endtask

  task automatic test_reset;
    clear = 1'b1;
    din   = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({dout, dout_valid, ts_num, odd_frame, frame_sync, fas_err} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 00000",
               {dout, dout_valid, ts_num, odd_frame, frame_sync, fas_err});
    end
    checks++;
    if ({t1_dout, t1_dout_valid, t1_ts_num, t1_odd_frame, t1_frame_sync, t1_fas_err} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs_t1: got %h expected 00000",
               {t1_dout, t1_dout_valid, t1_ts_num, t1_odd_frame, t1_frame_sync, t1_fas_err});
    end
    @(negedge clock);
    clear = 1'b0;
    send_ones(20);
    checks++;
    if ({dout_valid, frame_sync, fas_err} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: valid/sync/err=%b expected 000",
               {dout_valid, frame_sync, fas_err});
    end
  endtask

  task automatic test_aligned;
    logic [7:0] v;
    logic       odd;
    pulse_reset();
    send_ones(37);
    for (int fr = 0; fr < 2; fr++) begin
      for (int ts = 0; ts < 32; ts++) begin
        send_byte(exp_byte(ts, 1'(fr % 2)));
        checks++;
        if ({dout_valid, frame_sync} !== 2'b00) begin
          errors++;
          $display("FAIL align_pre fr%0d ts%0d: valid/sync=%b expected 00",
                   fr, ts, {dout_valid, frame_sync});
        end
      end
    end
    v = exp_byte(0, 1'b0);
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    checks++;
    if (frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL align_511: frame_sync=%b expected 0", frame_sync);
    end
    send_bit(v[0]);
    checks++;
    if ({frame_sync, dout_valid} !== 2'b10) begin
      errors++;
      $display("FAIL align_512: sync/valid=%b expected 10", {frame_sync, dout_valid});
    end
    for (int fr = 2; fr <= 4; fr++) begin
      odd = 1'(fr % 2);
      for (int ts = (fr == 2) ? 1 : 0; ts <= ((fr == 4) ? 0 : 31); ts++) begin
        v = exp_byte(ts, odd);
        for (int i = 7; i >= 0; i--) begin
          send_bit(v[i]);
          checks++;
          if (i != 0) begin
            if (dout_valid !== 1'b0) begin
              errors++;
              $display("FAIL strobe_gap fr%0d ts%0d bit%0d: valid=%b expected 0",
                       fr, ts, 7 - i, dout_valid);
            end
          end else if ({dout_valid, dout, ts_num, odd_frame, frame_sync, fas_err} !==
                       {1'b1, v, 5'(ts), odd, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL byte_out fr%0d ts%0d: got v=%b d=%h ts=%0d odd=%b sync=%b err=%b expected 1 %h %0d %b 1 0",
                     fr, ts, dout_valid, dout, ts_num, odd_frame, frame_sync, fas_err,
                     v, ts, odd);
          end
        end
      end
    end
  endtask

  task automatic test_false_fas;
    logic [7:0] v;
    pulse_reset();
    send_ones(11);
    // Partial frame whose TS5 payload imitates the FAS word.
    for (int ts = 1; ts < 32; ts++) begin
      send_byte((ts == 5) ? 8'h1B : exp_byte(ts, 1'b1));
      checks++;
      if ({dout_valid, frame_sync} !== 2'b00) begin
        errors++;
        $display("FAIL false_pre ts%0d: valid/sync=%b expected 00", ts, {dout_valid, frame_sync});
      end
    end
    for (int fr = 0; fr < 4; fr++) begin
      for (int ts = 0; ts < 32; ts++) begin
        send_byte(exp_byte(ts, 1'(fr % 2)));
        checks++;
        if ({dout_valid, frame_sync} !== 2'b00) begin
          errors++;
          $display("FAIL false_search fr%0d ts%0d: valid/sync=%b expected 00",
                   fr, ts, {dout_valid, frame_sync});
        end
      end
    end
    v = 8'h1B;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    checks++;
    if (frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL false_early_sync: frame_sync=%b expected 0", frame_sync);
    end
    send_bit(v[0]);
    checks++;
    if (frame_sync !== 1'b1) begin
      errors++;
      $display("FAIL false_then_true_sync: frame_sync=%b expected 1", frame_sync);
    end
  endtask

  task automatic test_loss;
    logic exp_sync;
    align_stream();
    send_ts_range(1'b1, 0, 31);
    for (int k = 1; k <= 3; k++) begin
      exp_sync = (k < 3);
      send_byte(8'h00);
      checks++;
      if ({dout_valid, fas_err, dout, ts_num, odd_frame, frame_sync} !==
          {1'b1, 1'b1, 8'h00, 5'd0, 1'b0, exp_sync}) begin
        errors++;
        $display("FAIL loss_ts0 err%0d: got v=%b e=%b d=%h ts=%0d odd=%b sync=%b expected 1 1 00 0 0 %b",
                 k, dout_valid, fas_err, dout, ts_num, odd_frame, frame_sync, exp_sync);
      end
      send_byte(8'h01);
      checks++;
      if ({dout_valid, fas_err, frame_sync} !== {exp_sync, 1'b0, exp_sync}) begin
        errors++;
        $display("FAIL loss_ts1 err%0d: valid/err/sync=%b expected %b0%b",
                 k, {dout_valid, fas_err, frame_sync}, exp_sync, exp_sync);
      end
      for (int ts = 2; ts < 32; ts++) begin
        send_byte(exp_byte(ts, 1'b0));
        if (k == 3) begin
          checks++;
          if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL loss_no_output ts%0d: valid=%b expected 0", ts, dout_valid);
          end
        end
      end
      if (k < 3) send_ts_range(1'b1, 0, 31);
    end
  endtask

  task automatic test_recovery;
    logic [4:0] pat;
    logic       err;
    pat = 5'b11011;  // bit k set = even frame k carries a corrupted FAS
    align_stream();
    for (int k = 0; k < 5; k++) begin
      err = pat[k];
      send_ts_range(1'b1, 0, 31);
      send_byte(err ? 8'h00 : 8'h1B);
      checks++;
      if ({dout_valid, fas_err, frame_sync} !== {1'b1, err, 1'b1}) begin
        errors++;
        $display("FAIL recov_ts0 k%0d: valid/err/sync=%b expected 1%b1",
                 k, {dout_valid, fas_err, frame_sync}, err);
      end
      send_ts_range(1'b0, 1, 31);
    end
    send_ts_range(1'b1, 0, 31);
    send_byte(8'h00);
    checks++;
    if ({fas_err, frame_sync} !== 2'b10) begin
      errors++;
      $display("FAIL recov_third_err: err/sync=%b expected 10", {fas_err, frame_sync});
    end
  endtask

  task automatic test_midreset;
    logic [7:0] v;
    align_stream();
    send_ts_range(1'b1, 0, 16);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    checks++;
    if ({frame_sync, dout, ts_num, odd_frame} !== {1'b1, 8'h10, 5'd16, 1'b1}) begin
      errors++;
      $display("FAIL midreset_pre: sync=%b d=%h ts=%0d odd=%b expected 1 10 16 1",
               frame_sync, dout, ts_num, odd_frame);
    end
    #2;
    clear = 1'b1;
    #1;
    checks++;
    if ({dout, dout_valid, ts_num, odd_frame, frame_sync, fas_err} !== 17'h0) begin
      errors++;
      $display("FAIL midreset_async: got %h expected 00000",
               {dout, dout_valid, ts_num, odd_frame, frame_sync, fas_err});
    end
    @(negedge clock);
    clear = 1'b0;
    send_ones(37);
    for (int fr = 0; fr < 2; fr++) begin
      for (int ts = 0; ts < 32; ts++) begin
        send_byte(exp_byte(ts, 1'(fr % 2)));
        checks++;
        if ({dout_valid, frame_sync} !== 2'b00) begin
          errors++;
          $display("FAIL midreset_realign fr%0d ts%0d: valid/sync=%b expected 00",
                   fr, ts, {dout_valid, frame_sync});
        end
      end
    end
    v = 8'h1B;
    for (int i = 7; i >= 1; i--) send_bit(v[i]);
    checks++;
    if (frame_sync !== 1'b0) begin
      errors++;
      $display("FAIL midreset_early: frame_sync=%b expected 0", frame_sync);
    end
    send_bit(v[0]);
    checks++;
    if (frame_sync !== 1'b1) begin
      errors++;
      $display("FAIL midreset_resync: frame_sync=%b expected 1", frame_sync);
    end
  endtask

  task automatic test_thresh1;
    align_stream();
    checks++;
    if ({frame_sync, t1_frame_sync} !== 2'b11) begin
      errors++;
      $display("FAIL t1_aligned: sync/t1_sync=%b expected 11", {frame_sync, t1_frame_sync});
    end
    send_ts_range(1'b1, 0, 31);
    send_byte(8'h00);
    checks++;
    if ({t1_dout_valid, t1_fas_err, t1_frame_sync, frame_sync} !== 4'b1101) begin
      errors++;
      $display("FAIL t1_single_loss: t1 valid/err/sync, sync=%b expected 1101",
               {t1_dout_valid, t1_fas_err, t1_frame_sync, frame_sync});
    end
    send_byte(8'h01);
    checks++;
    if ({t1_dout_valid, dout_valid} !== 2'b01) begin
      errors++;
      $display("FAIL t1_after_loss: t1_valid/valid=%b expected 01", {t1_dout_valid, dout_valid});
    end
  endtask

  initial begin
    clear = 1'b1;
    din   = 1'b0;
    test_reset();
    test_aligned();
    test_false_fas();
    test_loss();
    test_recovery();
    test_midreset();
    test_thresh1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/e1_demux_controller.md
Name: e1_demux_controller

Overview:
- Frame-alignment and timeslot sequencer for the E1 demultiplexer path. It receives the recovered serial E1 bit stream, one bit per clock.
- It searches for the frame alignment signal (FAS) in TS0 and confirms alignment with the standard FAS/NFAS/FAS procedure.
- Once aligned, it deserialises the stream into bytes tagged with a timeslot number, replacing free-running byte counting with frame-locked sequencing.
- It supervises loss of alignment and returns to search when alignment is lost.

Parameters:
- FAS_PATTERN, 7'b0011011, 7 FAS bits following the Si bit, in transmission order.
- LOSS_THRESH, 3, number of consecutive errored FAS words that declares loss of frame alignment.
- NUM_TS, 32, timeslots per frame; fixed at 8 bits per timeslot.

Ports:
- clock  input  1  bit clock; one serial bit sampled per rising edge.
- clear  input  1  asynchronous active-high reset.
- din  input  1  serial E1 data, MSB of each timeslot first.
- dout  output  8  last completed timeslot byte; MSB = first received bit.
- dout_valid  output  1  one-cycle strobe: dout/ts_num updated (SYNC state only).
- ts_num  output  5  timeslot index of dout, 0..31.
- odd_frame  output  1  1 = dout belongs to an NFAS (odd) frame.
- frame_sync  output  1  1 while in SYNC state.
- fas_err  output  1  one-cycle strobe on each errored FAS word in SYNC.

Behaviour:
- Reset (clear=1, asynchronous): state=SEARCH; internal shift register sreg=8'h00; bit_cnt=0; ts_cnt=0; parity=0; err_cnt=0; dout=8'h00; dout_valid=0; ts_num=0; odd_frame=0; frame_sync=0; fas_err=0. Reset mid-frame discards all alignment.
- Shift register:
  - Every rising edge, sreg <= {sreg[6:0], din}.
  - "Incoming byte" B = {sreg[6:0], din}, evaluated on the same edge.
- Counters:
  - Outside SEARCH, bit_cnt increments 0..7 and wraps.
  - On bit_cnt==7, ts_cnt increments 0..NUM_TS-1 and wraps to 0; the wrap toggles parity.
- States: SEARCH, CHK_NFAS, CHK_FAS, SYNC.
- SEARCH:
  - Each edge, compare B[6:0] with FAS_PATTERN.
  - On match: bit_cnt<=0, ts_cnt<=1, parity<=0 (the matched frame is even), go to CHK_NFAS.
  - No dout_valid is issued in SEARCH.
- CHK_NFAS:
  - At the edge where ts_cnt==0 and bit_cnt==7 (256 bits after the FAS byte end; parity=1): if B[6]==1, go to CHK_FAS; else go to SEARCH.
- CHK_FAS:
  - At the next ts_cnt==0, bit_cnt==7 edge (parity=0): if B[6:0]==FAS_PATTERN, go to SYNC with err_cnt=0; else go to SEARCH.
  - Alignment is therefore declared 512 bits after the first FAS end.
- SYNC:
  - frame_sync=1, registered; it asserts on the edge that enters SYNC.
  - At every bit_cnt==7 edge: dout<=B, ts_num<=ts_cnt, odd_frame<=parity, and dout_valid=1 for exactly the following cycle. This gives a latency of 1 clock from the last bit of the byte.
  - TS0 bytes are output as well.
  - On TS0 of even frames, B[6:0]!=FAS_PATTERN is an error: fas_err pulses and err_cnt increments.
  - A correct FAS word clears err_cnt to 0.
  - NFAS contents are not checked in SYNC.
  - When err_cnt reaches LOSS_THRESH: go to SEARCH and set frame_sync=0. The same edge still emits the TS0 byte with dout_valid and fas_err.
  - err_cnt saturates and never wraps.
- Re-search after loss:
  - Searching starts on the edge following entry to SEARCH.
  - bit_cnt and ts_cnt hold until the next match; parity is reset on match.
- Width rules:
  - ts_cnt is 5 bits and must equal $clog2(NUM_TS).
  - err_cnt is wide enough for LOSS_THRESH.
- Simultaneous events: a FAS check and a byte output on the same edge are both performed; loss takes priority for the state transition only.

Test Plan:
- Aligned stream: random-prefix 37 bits, then frames with TS0 even=8'h1B, TS0 odd=8'h40, TSn=n -> frame_sync rises 512 bits after first FAS end. Thereafter dout_valid strobes every 8 clocks, with ts_num 0..31 and dout==ts_num for n≥1, and odd_frame alternating per frame.
- False FAS: payload byte 8'h1B in TS5 before true alignment, NFAS bit2=0 at +256 -> return to SEARCH, no dout_valid; later true alignment still acquired.
- Loss of alignment: in SYNC, corrupt FAS on 3 consecutive even frames -> fas_err pulses 3 times; frame_sync falls on the third errored TS0 edge.
- Error recovery: in SYNC, 2 errored FAS then 1 correct FAS, then 2 errored -> frame_sync stays 1 and err_cnt resets.
- Reset mid-operation: assert clear asynchronously mid-TS17 while in SYNC -> all outputs 0 immediately, state SEARCH; after release, full realignment takes 512+ bits.
- Parameter check: LOSS_THRESH=1 -> a single errored FAS drops frame_sync on that TS0 edge.
